// File: rtl/msg_uart_tx.sv
// 8N1 UART transmitter fed by a byte FIFO, with a 10-byte frame monitor (0x5A/0x5B header, matching tail).
// Latency: RD strobe to start bit is 2 cycles, one byte every 10*CLKS_PER_BIT+2 cycles; an empty FIFO simply idles the line.
module msg_uart_tx #(
   parameter int CLKS_PER_BIT = 868
) (
   input  logic        OPB_CLK,
   input  logic        OPB_RST_N,
   input  logic        TX_FIFO_EMPTY,
   output logic        TX_FIFO_RD,
   input  logic [7:0]  TX_FIFO_Q,
   output logic        UART_TXD,
   output logic        TX_BUSY,
   output logic        FRAME_DONE,
   output logic        FRAME_ERR,
   output logic [15:0] FRAME_CNT
);

   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

   typedef enum logic [2:0] {IDLE, FETCH, LOAD, START, DATA, STOP} state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] clk_cnt_q, clk_cnt_d;
   logic [2:0]    bit_idx_q, bit_idx_d;
   logic [7:0]    shift_q, shift_d;
   logic [3:0]    byte_idx_q, byte_idx_d;
   logic [7:0]    tail_q, tail_d;
   logic          done_pend_q, done_pend_d;
   logic          txd_q, txd_d;
   logic          rd_q, rd_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic          err_q, err_d;
   logic [15:0]   frame_cnt_q, frame_cnt_d;
   logic          bit_end;

   assign bit_end = (clk_cnt_q == CW'(CLKS_PER_BIT - 1));

   always_comb begin
      state_d     = state_q;
      clk_cnt_d   = clk_cnt_q;
      bit_idx_d   = bit_idx_q;
      shift_d     = shift_q;
      byte_idx_d  = byte_idx_q;
      tail_d      = tail_q;
      done_pend_d = done_pend_q;
      frame_cnt_d = frame_cnt_q;
      done_d      = 1'b0;
      err_d       = 1'b0;

      case (state_q)
         IDLE: begin
            if (!TX_FIFO_EMPTY) state_d = FETCH;
         end
         FETCH: begin
            state_d = LOAD;
         end
         LOAD: begin
            shift_d   = TX_FIFO_Q;
            clk_cnt_d = '0;
            state_d   = START;
            // A bad header is still sent; the monitor just stays at index 0 to resync.
            if (byte_idx_q == 4'd0) begin
               if (TX_FIFO_Q == 8'h5A || TX_FIFO_Q == 8'h5B) begin
                  tail_d     = (TX_FIFO_Q == 8'h5A) ? 8'hA5 : 8'hA4;
                  byte_idx_d = 4'd1;
               end else begin
                  err_d = 1'b1;
               end
            end else if (byte_idx_q == 4'd9) begin
               if (TX_FIFO_Q == tail_q) done_pend_d = 1'b1;
               else                     err_d       = 1'b1;
               byte_idx_d = 4'd0;
            end else begin
               byte_idx_d = byte_idx_q + 4'd1;
            end
         end
         START: begin
            if (bit_end) begin
               clk_cnt_d = '0;
               bit_idx_d = 3'd0;
               state_d   = DATA;
            end else begin
               clk_cnt_d = clk_cnt_q + CW'(1);
            end
         end
         DATA: begin
            if (bit_end) begin
               clk_cnt_d = '0;
               if (bit_idx_q == 3'd7) state_d = STOP;
               else                   bit_idx_d = bit_idx_q + 3'd1;
            end else begin
               clk_cnt_d = clk_cnt_q + CW'(1);
            end
         end
         STOP: begin
            if (bit_end) begin
               clk_cnt_d = '0;
               state_d   = TX_FIFO_EMPTY ? IDLE : FETCH;
               if (done_pend_q) begin
                  done_d      = 1'b1;
                  done_pend_d = 1'b0;
                  frame_cnt_d = frame_cnt_q + 16'd1;
               end
            end else begin
               clk_cnt_d = clk_cnt_q + CW'(1);
            end
         end
         default: state_d = IDLE;
      endcase

      // Outputs are decoded from the next state so the registers line up with the state they describe.
      rd_d   = (state_d == FETCH);
      busy_d = (state_d != IDLE);
      case (state_d)
         START:   txd_d = 1'b0;
         DATA:    txd_d = shift_d[bit_idx_d];
         default: txd_d = 1'b1;
      endcase
   end

   always_ff @(posedge OPB_CLK) begin
      if (!OPB_RST_N) begin
         state_q     <= IDLE;
         clk_cnt_q   <= '0;
         bit_idx_q   <= 3'd0;
         shift_q     <= 8'h00;
         byte_idx_q  <= 4'd0;
         tail_q      <= 8'h00;
         done_pend_q <= 1'b0;
         txd_q       <= 1'b1;
         rd_q        <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         frame_cnt_q <= 16'h0000;
      end else begin
         state_q     <= state_d;
         clk_cnt_q   <= clk_cnt_d;
         bit_idx_q   <= bit_idx_d;
         shift_q     <= shift_d;
         byte_idx_q  <= byte_idx_d;
         tail_q      <= tail_d;
         done_pend_q <= done_pend_d;
         txd_q       <= txd_d;
         rd_q        <= rd_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         err_q       <= err_d;
         frame_cnt_q <= frame_cnt_d;
      end
   end

   assign TX_FIFO_RD = rd_q;
   assign UART_TXD   = txd_q;
   assign TX_BUSY    = busy_q;
   assign FRAME_DONE = done_q;
   assign FRAME_ERR  = err_q;
   assign FRAME_CNT  = frame_cnt_q;

endmodule

// File: tb/tb_msg_uart_tx.sv
// Directed bench for msg_uart_tx at CLKS_PER_BIT=4 with a FIFO model and a serial line decoder.
module tb_msg_uart_tx;
   localparam int N = 4;

   logic        OPB_CLK = 1'b0;
   logic        OPB_RST_N = 1'b0;
   wire         TX_FIFO_EMPTY;
   logic        TX_FIFO_RD;
   logic [7:0]  TX_FIFO_Q = 8'h00;
   logic        UART_TXD;
   logic        TX_BUSY;
   logic        FRAME_DONE;
   logic        FRAME_ERR;
   logic [15:0] FRAME_CNT;

   msg_uart_tx #(.CLKS_PER_BIT(N)) dut (
      .OPB_CLK       (OPB_CLK),
      .OPB_RST_N     (OPB_RST_N),
      .TX_FIFO_EMPTY (TX_FIFO_EMPTY),
      .TX_FIFO_RD    (TX_FIFO_RD),
      .TX_FIFO_Q     (TX_FIFO_Q),
      .UART_TXD      (UART_TXD),
      .TX_BUSY       (TX_BUSY),
      .FRAME_DONE    (FRAME_DONE),
      .FRAME_ERR     (FRAME_ERR),
      .FRAME_CNT     (FRAME_CNT)
   );

   always #5 OPB_CLK = ~OPB_CLK;

   // Upstream FIFO: stimulus owns the write side, this block owns the read side.
   logic [7:0] mem [0:1023];
   int         wr_ptr = 0;
   int         rd_ptr = 0;
   assign TX_FIFO_EMPTY = (rd_ptr == wr_ptr);

   always @(posedge OPB_CLK) begin
      if (TX_FIFO_RD) begin
         TX_FIFO_Q <= mem[rd_ptr % 1024];
         rd_ptr    <= rd_ptr + 1;
      end
   end

   // Event counters and a mid-bit sampling serial decoder.
   int         cyc = 0;
   int         rd_cnt = 0, done_cnt = 0, err_cnt = 0, both_cnt = 0, rd_empty_cnt = 0;
   int         last_err_cyc = 0;
   logic       rx_active = 1'b0;
   int         rx_ph = 0;
   logic [7:0] rx_byte = 8'h00;
   int         stop_bad = 0;
   logic [7:0] rx_q [$];

   always @(negedge OPB_CLK) begin
      cyc <= cyc + 1;
      if (TX_FIFO_RD === 1'b1) rd_cnt <= rd_cnt + 1;
      if (TX_FIFO_RD === 1'b1 && rd_ptr == wr_ptr) rd_empty_cnt <= rd_empty_cnt + 1;
      if (FRAME_DONE === 1'b1) done_cnt <= done_cnt + 1;
      if (FRAME_ERR === 1'b1) begin
         err_cnt      <= err_cnt + 1;
         last_err_cyc <= cyc;
      end
      if (FRAME_DONE === 1'b1 && FRAME_ERR === 1'b1) both_cnt <= both_cnt + 1;
      if (!OPB_RST_N) begin
         rx_active <= 1'b0;
      end else if (!rx_active) begin
         if (UART_TXD === 1'b0) begin
            rx_active <= 1'b1;
            rx_ph     <= 1;
         end
      end else begin
         rx_ph <= rx_ph + 1;
         for (int k = 0; k < 8; k++)
            if (rx_ph == N * (k + 1) + 2) rx_byte[k] <= UART_TXD;
         if (rx_ph == N * 9 + 2) begin
            rx_active <= 1'b0;
            if (UART_TXD === 1'b1) rx_q.push_back(rx_byte);
            else                   stop_bad <= stop_bad + 1;
         end
      end
   end

   int errors = 0;
   int checks = 0;
   logic [7:0] good_frame [10];

   task automatic push(input logic [7:0] b);
      mem[wr_ptr % 1024] = b;
      wr_ptr = wr_ptr + 1;
   endtask

   task automatic wait_idle(output bit ok);
      int quiet;
      quiet = 0;
      ok = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         @(negedge OPB_CLK);
         if (!TX_BUSY && TX_FIFO_EMPTY) quiet++;
         else quiet = 0;
         if (quiet >= 4) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic wait_rd(output bit ok, output int c);
      ok = 1'b0;
      c = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge OPB_CLK);
         if (TX_FIFO_RD === 1'b1) begin
            ok = 1'b1;
            c = cyc;
            break;
         end
      end
   endtask

   task automatic pulse_reset();
      @(negedge OPB_CLK);
      OPB_RST_N = 1'b0;
      repeat (2) @(negedge OPB_CLK);
      OPB_RST_N = 1'b1;
   endtask

   task automatic test_reset();
      OPB_RST_N = 1'b0;
      repeat (3) @(negedge OPB_CLK);
      checks++; if (UART_TXD !== 1'b1) begin errors++; $display("FAIL rst_txd got=%b want=1", UART_TXD); end
      checks++; if (TX_BUSY !== 1'b0) begin errors++; $display("FAIL rst_busy got=%b want=0", TX_BUSY); end
      checks++; if (TX_FIFO_RD !== 1'b0) begin errors++; $display("FAIL rst_rd got=%b want=0", TX_FIFO_RD); end
      checks++; if (FRAME_DONE !== 1'b0) begin errors++; $display("FAIL rst_done got=%b want=0", FRAME_DONE); end
      checks++; if (FRAME_ERR !== 1'b0) begin errors++; $display("FAIL rst_err got=%b want=0", FRAME_ERR); end
      checks++; if (FRAME_CNT !== 16'h0000) begin errors++; $display("FAIL rst_cnt got=%h want=0000", FRAME_CNT); end
      OPB_RST_N = 1'b1;
      repeat (2) @(negedge OPB_CLK);
      checks++; if (UART_TXD !== 1'b1 || TX_BUSY !== 1'b0) begin errors++; $display("FAIL idle_empty txd=%b busy=%b want 1/0", UART_TXD, TX_BUSY); end
   endtask

   task automatic test_single_byte();
      logic [9:0] line_exp;
      bit ok;
      int c, bad, rd0, rx0;
      line_exp = 10'b1010110100;
      rd0 = rd_cnt;
      rx0 = rx_q.size();
      push(8'h5A);
      wait_rd(ok, c);
      checks++; if (!ok) begin errors++; $display("FAIL single_rd got=timeout want=RD pulse"); end
      @(negedge OPB_CLK);
      checks++; if (UART_TXD !== 1'b1 || TX_BUSY !== 1'b1) begin errors++; $display("FAIL single_load txd=%b busy=%b want 1/1", UART_TXD, TX_BUSY); end
      for (int b = 0; b < 10; b++) begin
         bad = 0;
         for (int j = 0; j < N; j++) begin
            @(negedge OPB_CLK);
            if (UART_TXD !== line_exp[b] || TX_BUSY !== 1'b1) bad++;
         end
         checks++; if (bad != 0) begin errors++; $display("FAIL single_bit%0d got %0d bad samples want line=%b busy=1", b, bad, line_exp[b]); end
      end
      @(negedge OPB_CLK);
      checks++; if (TX_BUSY !== 1'b0 || UART_TXD !== 1'b1) begin errors++; $display("FAIL single_busy_fall42 busy=%b txd=%b want 0/1", TX_BUSY, UART_TXD); end
      wait_idle(ok);
      checks++; if (!ok || rd_cnt - rd0 != 1) begin errors++; $display("FAIL single_rd_count got=%0d ok=%0d want=1", rd_cnt - rd0, ok); end
      checks++; if (rx_q.size() != rx0 + 1 || rx_q[rx_q.size() - 1] !== 8'h5A) begin errors++; $display("FAIL single_rx got n=%0d want one byte 5A", rx_q.size() - rx0); end
   endtask

   task automatic test_back_to_back();
      bit ok;
      int c, prev, badgap, d0, e0, rx0, badrx;
      d0 = done_cnt; e0 = err_cnt; rx0 = rx_q.size();
      for (int i = 0; i < 10; i++) push(good_frame[i]);
      badgap = 0; prev = 0;
      for (int i = 0; i < 10; i++) begin
         wait_rd(ok, c);
         if (!ok) badgap++;
         else if (i > 0 && c - prev != 10 * N + 2) badgap++;
         prev = c;
      end
      checks++; if (badgap != 0) begin errors++; $display("FAIL b2b_gap got %0d bad spacings want all %0d cycles", badgap, 10 * N + 2); end
      wait_idle(ok);
      checks++; if (!ok) begin errors++; $display("FAIL b2b_idle got=timeout want=idle"); end
      checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL b2b_done got=%0d want=1", done_cnt - d0); end
      checks++; if (err_cnt - e0 != 0) begin errors++; $display("FAIL b2b_err got=%0d want=0", err_cnt - e0); end
      checks++; if (FRAME_CNT !== 16'd1) begin errors++; $display("FAIL b2b_cnt got=%0d want=1", FRAME_CNT); end
      badrx = 0;
      if (rx_q.size() != rx0 + 10) badrx = 99;
      else for (int i = 0; i < 10; i++) if (rx_q[rx0 + i] !== good_frame[i]) badrx++;
      checks++; if (badrx != 0) begin errors++; $display("FAIL b2b_rx got %0d bad bytes want 0", badrx); end
   endtask

   task automatic test_wrong_tail();
      bit ok;
      int c, rd10, d0, e0;
      d0 = done_cnt; e0 = err_cnt;
      push(8'h5B);
      for (int i = 0; i < 8; i++) push(8'h00);
      push(8'hA5);
      rd10 = 0;
      for (int i = 0; i < 10; i++) begin
         wait_rd(ok, c);
         rd10 = c;
      end
      wait_idle(ok);
      checks++; if (!ok) begin errors++; $display("FAIL tail_idle got=timeout want=idle"); end
      checks++; if (err_cnt - e0 != 1) begin errors++; $display("FAIL tail_err got=%0d want=1", err_cnt - e0); end
      checks++; if (last_err_cyc <= rd10 || last_err_cyc > rd10 + 2) begin errors++; $display("FAIL tail_err_time got=%0d want in (%0d,%0d]", last_err_cyc, rd10, rd10 + 2); end
      checks++; if (done_cnt - d0 != 0 || FRAME_CNT !== 16'd1) begin errors++; $display("FAIL tail_nodone done=%0d cnt=%0d want 0/1", done_cnt - d0, FRAME_CNT); end
      d0 = done_cnt; e0 = err_cnt;
      for (int i = 0; i < 10; i++) push(good_frame[i]);
      wait_idle(ok);
      checks++; if (!ok || done_cnt - d0 != 1 || err_cnt - e0 != 0 || FRAME_CNT !== 16'd2) begin errors++; $display("FAIL tail_resync done=%0d err=%0d cnt=%0d want 1/0/2", done_cnt - d0, err_cnt - e0, FRAME_CNT); end
   endtask

   task automatic test_stray_header();
      bit ok;
      int d0, e0;
      d0 = done_cnt; e0 = err_cnt;
      push(8'h33);
      for (int i = 0; i < 10; i++) push(good_frame[i]);
      wait_idle(ok);
      checks++; if (!ok || err_cnt - e0 != 1) begin errors++; $display("FAIL stray_err got=%0d want=1", err_cnt - e0); end
      checks++; if (done_cnt - d0 != 1 || FRAME_CNT !== 16'd3) begin errors++; $display("FAIL stray_done done=%0d cnt=%0d want 1/3", done_cnt - d0, FRAME_CNT); end
   endtask

   task automatic test_mid_frame_empty();
      bit ok;
      int d0, e0;
      d0 = done_cnt; e0 = err_cnt;
      for (int i = 0; i < 5; i++) push(good_frame[i]);
      wait_idle(ok);
      repeat (20) @(negedge OPB_CLK);
      checks++; if (!ok || done_cnt - d0 != 0 || UART_TXD !== 1'b1) begin errors++; $display("FAIL gap_hold done=%0d txd=%b want 0/1", done_cnt - d0, UART_TXD); end
      for (int i = 5; i < 10; i++) push(good_frame[i]);
      wait_idle(ok);
      checks++; if (!ok || done_cnt - d0 != 1 || err_cnt - e0 != 0 || FRAME_CNT !== 16'd4) begin errors++; $display("FAIL gap_done done=%0d err=%0d cnt=%0d want 1/0/4", done_cnt - d0, err_cnt - e0, FRAME_CNT); end
   endtask

   task automatic test_reset_mid_byte();
      bit ok;
      int c, rd0, rx0, rd_in_rst;
      rd0 = rd_cnt; rx0 = rx_q.size();
      push(8'h5A);
      wait_rd(ok, c);
      checks++; if (!ok) begin errors++; $display("FAIL mid_rd got=timeout want=RD pulse"); end
      repeat (18) @(negedge OPB_CLK);
      checks++; if (UART_TXD !== 1'b1 || TX_BUSY !== 1'b1) begin errors++; $display("FAIL mid_bit3 txd=%b busy=%b want 1/1", UART_TXD, TX_BUSY); end
      OPB_RST_N = 1'b0;
      @(negedge OPB_CLK);
      checks++; if (UART_TXD !== 1'b1 || TX_BUSY !== 1'b0) begin errors++; $display("FAIL mid_rst_line txd=%b busy=%b want 1/0", UART_TXD, TX_BUSY); end
      checks++; if (FRAME_CNT !== 16'd0) begin errors++; $display("FAIL mid_rst_cnt got=%0d want=0", FRAME_CNT); end
      rd_in_rst = 0;
      for (int i = 0; i < 3; i++) begin
         if (TX_FIFO_RD !== 1'b0) rd_in_rst++;
         @(negedge OPB_CLK);
      end
      checks++; if (rd_in_rst != 0) begin errors++; $display("FAIL mid_rst_rd got=%0d want=0", rd_in_rst); end
      OPB_RST_N = 1'b1;
      repeat (60) @(negedge OPB_CLK);
      checks++; if (rd_cnt - rd0 != 1 || TX_BUSY !== 1'b0 || rx_q.size() != rx0) begin errors++; $display("FAIL mid_no_reread rd=%0d busy=%b rx=%0d want 1/0/0", rd_cnt - rd0, TX_BUSY, rx_q.size() - rx0); end
   endtask

   task automatic test_cnt_wrap();
      bit ok;
      int d0;
      @(negedge OPB_CLK);
      force dut.frame_cnt_q = 16'hFFFF;
      @(negedge OPB_CLK);
      release dut.frame_cnt_q;
      @(negedge OPB_CLK);
      checks++; if (FRAME_CNT !== 16'hFFFF) begin errors++; $display("FAIL wrap_preset got=%h want=ffff", FRAME_CNT); end
      d0 = done_cnt;
      for (int i = 0; i < 10; i++) push(good_frame[i]);
      wait_idle(ok);
      checks++; if (!ok || done_cnt - d0 != 1 || FRAME_CNT !== 16'h0000) begin errors++; $display("FAIL wrap_cnt got=%h done=%0d want 0000/1", FRAME_CNT, done_cnt - d0); end
   endtask

   initial begin
      good_frame = '{8'h5A, 8'h00, 8'h00, 8'h10, 8'h04, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'hA5};
      test_reset();
      test_single_byte();
      pulse_reset();
      test_back_to_back();
      test_wrong_tail();
      test_stray_header();
      test_mid_frame_empty();
      test_reset_mid_byte();
      test_cnt_wrap();
      checks++; if (both_cnt != 0) begin errors++; $display("FAIL done_err_overlap got=%0d want=0", both_cnt); end
      checks++; if (rd_empty_cnt != 0) begin errors++; $display("FAIL rd_when_empty got=%0d want=0", rd_empty_cnt); end
      checks++; if (stop_bad != 0) begin errors++; $display("FAIL stop_bits got=%0d bad want=0", stop_bad); end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/msg_uart_tx.md
MSG_UART_TX -- requirements
Module: msg_uart_tx

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset: OPB_CLK and OPB_RST_N.
REQ-002 Parameter CLKS_PER_BIT SHALL default to 868 and SHALL set the OPB_CLK cycles per UART bit (100 MHz / 115200 baud).
REQ-003 OPB_CLK  input  1  system clock; all logic SHALL be clocked on its rising edge.
REQ-004 OPB_RST_N  input  1  synchronous reset, active low.
REQ-005 TX_FIFO_EMPTY  input  1  high when the upstream byte FIFO holds no data.
REQ-006 TX_FIFO_RD  output  1  one-cycle read strobe to the FIFO.
REQ-007 TX_FIFO_Q  input  8  FIFO read data, valid exactly one cycle after TX_FIFO_RD.
REQ-008 UART_TXD  output  1  serial line, 8N1, LSB first, idle high.
REQ-009 TX_BUSY  output  1  high in every state other than IDLE.
REQ-010 FRAME_DONE  output  1  one-cycle pulse when a valid 10-byte message frame has been fully serialised.
REQ-011 FRAME_ERR  output  1  one-cycle pulse on a header or tail violation.
REQ-012 FRAME_CNT  output  16  count of valid frames; wraps from 0xFFFF to 0x0000.

Function
REQ-013 The FSM SHALL have exactly these states: IDLE, FETCH, LOAD, START, DATA, STOP.
REQ-014 IDLE SHALL go to FETCH when TX_FIFO_EMPTY=0, and SHALL otherwise stay in IDLE with UART_TXD=1.
REQ-015 TX_FIFO_RD SHALL be registered and SHALL be high only in FETCH, for exactly one cycle per byte; it is never asserted while TX_FIFO_EMPTY=1.
REQ-016 FETCH SHALL go to LOAD unconditionally; LOAD SHALL capture TX_FIFO_Q into the shift register and go to START.
REQ-017 A bit counter (0..CLKS_PER_BIT-1) SHALL time each bit and SHALL clear on every bit boundary.
REQ-018 START SHALL drive UART_TXD=0 for CLKS_PER_BIT cycles.
REQ-019 DATA SHALL drive bits 0..7, LSB first, for CLKS_PER_BIT cycles each, tracked by a 3-bit index.
REQ-020 STOP SHALL drive UART_TXD=1 for CLKS_PER_BIT cycles.
REQ-021 At the end of STOP the FSM SHALL go to FETCH if TX_FIFO_EMPTY=0, else to IDLE; back-to-back bytes therefore carry exactly 2 extra idle-high cycles (FETCH + LOAD).
REQ-022 UART_TXD SHALL be driven from a register (glitch-free); one byte SHALL occupy 10*CLKS_PER_BIT+2 cycles from FETCH entry to the next FETCH.
REQ-023 Frame monitor: a byte index (0..9) SHALL advance on each LOAD.
REQ-024 At index 0 the monitor SHALL accept only 0x5A or 0x5B and SHALL latch the expected tail: 0xA5 for 0x5A, 0xA4 for 0x5B.
REQ-025 An invalid header byte SHALL pulse FRAME_ERR, keep the index at 0 (resync), and still be transmitted.
REQ-026 At index 9 a byte equal to the latched tail SHALL pulse FRAME_DONE and increment FRAME_CNT at the end of that byte's STOP.
REQ-027 At index 9 a byte not equal to the latched tail SHALL pulse FRAME_ERR in LOAD, with no FRAME_CNT change; in both tail cases the index SHALL return to 0.
REQ-028 FRAME_DONE and FRAME_ERR SHALL never be high in the same cycle.
REQ-029 The FIFO going empty mid-frame SHALL not abort anything: the FSM idles and the frame index is held.

Reset
REQ-030 When OPB_RST_N=0 at a rising edge, the block SHALL set: state=IDLE, UART_TXD=1, TX_FIFO_RD=0, TX_BUSY=0, FRAME_DONE=0, FRAME_ERR=0, FRAME_CNT=0, frame index=0, bit counters=0.
REQ-031 A reset asserted mid-byte SHALL return UART_TXD high on the next edge; the partial byte is lost and the FIFO is not re-read.

Verification
REQ-032 Single byte 0x5A, CLKS_PER_BIT=4: one RD pulse, then line 0,0,1,0,1,1,0,1,0,1 (start, LSB-first data, stop) with each bit held 4 cycles; TX_BUSY falls after 42 cycles.
REQ-033 Frame 5A 00 00 10 04 DE AD BE EF A5 back-to-back: FRAME_DONE pulses once, FRAME_CNT=1, inter-byte gap is 2 cycles, no FRAME_ERR.
REQ-034 Frame 5B ... A5 (wrong tail): FRAME_ERR at the tenth LOAD, FRAME_CNT unchanged; the next 5A frame is accepted.
REQ-035 Leading stray byte 0x33 then a valid frame: one FRAME_ERR, then FRAME_DONE; FRAME_CNT=1.
REQ-036 OPB_RST_N low during DATA bit 3: UART_TXD=1 and TX_BUSY=0 next cycle, FRAME_CNT=0, no RD during reset.
REQ-037 FRAME_CNT preset path (65536 valid frames, or force): wraps to 0x0000 on the next FRAME_DONE.
